// File: rtl/mem_access_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_stage_if
// Description : Bundles the execute-side handshake, the write-back-side
//               handshake and the data-memory req/ack bus of the memory stage.
//               slave  - seen from the memory stage itself
//               master - seen from the surrounding pipeline / memory model
// Ports       : in_valid/in_ready + icode/valE/valA/valP      (execute side)
//               out_valid/out_ready + out_icode/out_valE/valM/mem_err
//                                                            (write-back side)
//               mem_req/mem_we/mem_addr/mem_wdata/mem_ack/mem_rdata
//                                                            (memory bus)
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_access_stage_if #(
    parameter int DATA_WID = 64
);
    logic                in_valid;
    logic                in_ready;
    logic [3:0]          icode;
    logic [DATA_WID-1:0] valE;
    logic [DATA_WID-1:0] valA;
    logic [DATA_WID-1:0] valP;

    logic                out_valid;
    logic                out_ready;
    logic [3:0]          out_icode;
    logic [DATA_WID-1:0] out_valE;
    logic [DATA_WID-1:0] valM;
    logic                mem_err;

    logic                mem_req;
    logic                mem_we;
    logic [DATA_WID-1:0] mem_addr;
    logic [DATA_WID-1:0] mem_wdata;
    logic                mem_ack;
    logic [DATA_WID-1:0] mem_rdata;

    modport slave (
        input  in_valid, icode, valE, valA, valP,
        output in_ready,
        output out_valid, out_icode, out_valE, valM, mem_err,
        input  out_ready,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport master (
        output in_valid, icode, valE, valA, valP,
        input  in_ready,
        input  out_valid, out_icode, out_valE, valM, mem_err,
        output out_ready,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_stage
// Description : Y86 memory stage. Accepts one instruction at a time from
//               execute, performs at most one 8-byte data access over a
//               req/ack bus (with address range check and bus timeout) and
//               presents icode/valE/valM/mem_err to write-back.
// Ports       : clk  - clock, all state on rising edge
//               rst  - synchronous reset, active-high
//               bus  - mem_access_stage_if.slave (pipeline + memory bus)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_stage #(
    parameter int DATA_WID = 64,
    parameter int MEM_SIZE = 8192,
    parameter int TIMEOUT  = 16
) (
    input  wire logic          clk,
    input  wire logic          rst,
    mem_access_stage_if.slave  bus
);

    localparam int                  c_cnt_w    = $clog2(TIMEOUT + 1);
    localparam logic [DATA_WID-1:0] c_max_addr = DATA_WID'(MEM_SIZE - 8);
    // Last REQ cycle before timeout: the count is compared before increment.
    localparam logic [c_cnt_w-1:0]  c_cnt_last = c_cnt_w'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    logic [c_cnt_w-1:0]  r_cnt;
    logic                r_in_ready;
    logic                r_out_valid;
    logic [3:0]          r_icode;
    logic [DATA_WID-1:0] r_valE;
    logic [DATA_WID-1:0] r_valM;
    logic                r_err;
    logic                r_req;
    logic                r_we;
    logic [DATA_WID-1:0] r_addr;
    logic [DATA_WID-1:0] r_wdata;

    logic                w_has_acc;
    logic                w_we;
    logic [DATA_WID-1:0] w_addr;
    logic [DATA_WID-1:0] w_wdata;
    logic                w_range_err;

    // Access decode from the incoming icode; only used on capture.
    always_comb begin
        w_has_acc = 1'b0;
        w_we      = 1'b0;
        w_addr    = bus.valE;
        w_wdata   = bus.valA;
        case (bus.icode)
            4'h4, 4'hA: begin           // rmmovq, pushq
                w_has_acc = 1'b1;
                w_we      = 1'b1;
            end
            4'h8: begin                 // call: push return address
                w_has_acc = 1'b1;
                w_we      = 1'b1;
                w_wdata   = bus.valP;
            end
            4'h5: begin                 // mrmovq
                w_has_acc = 1'b1;
            end
            4'h9, 4'hB: begin           // ret, popq read from the old stack pointer
                w_has_acc = 1'b1;
                w_addr    = bus.valA;
            end
            default: ;
        endcase
        // Unsigned compare: wrapped (huge) addresses are rejected too.
        w_range_err = (w_addr > c_max_addr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_icode     <= '0;
            r_valE      <= '0;
            r_valM      <= '0;
            r_err       <= 1'b0;
            r_req       <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_icode    <= bus.icode;
                        r_valE     <= bus.valE;
                        r_valM     <= '0;
                        r_err      <= 1'b0;
                        r_we       <= w_we;
                        r_addr     <= w_addr;
                        r_wdata    <= w_wdata;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        if (!w_has_acc) begin
                            r_state     <= S_DONE;
                            r_out_valid <= 1'b1;
                        end else if (w_range_err) begin
                            r_state     <= S_DONE;
                            r_out_valid <= 1'b1;
                            r_err       <= 1'b1;
                        end else begin
                            r_state <= S_REQ;
                            r_req   <= 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    // Ack is checked first so it wins over a same-cycle timeout.
                    if (bus.mem_ack) begin
                        if (!r_we) begin
                            r_valM <= bus.mem_rdata;
                        end
                        r_req       <= 1'b0;
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                    end else if (r_cnt == c_cnt_last) begin
                        r_req       <= 1'b0;
                        r_err       <= 1'b1;
                        r_valM      <= '0;
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_err       <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_req       <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_err       <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_icode = r_icode;
    assign bus.out_valE  = r_valE;
    assign bus.valM      = r_valM;
    assign bus.mem_err   = r_err;
    assign bus.mem_req   = r_req;
    assign bus.mem_we    = r_we;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;

endmodule
`default_nettype wire
